// File: rtl/gcd_datapath.sv
// gcd_datapath: the datapath half of a subtract-based Euclid GCD engine.
// The controller drives one strobe per cycle. This block holds the operand
// registers A and B and the difference register D. It returns registered
// compare flags to the controller and presents the final GCD with a
// one-cycle valid pulse.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   a_in, b_in        operands, sampled on ld
//   ld, comp, alu     load / compare / subtract strobes
//   a_sel, b_sel      write D into A / B
//   ans_en            capture the result into gcd_out
//   a_eq_b/lt/gt      registered compare flags
//   gcd_out           result register
//   gcd_valid         one-cycle pulse after gcd_out is written
//   proto_err         sticky; set when more than one strobe is high in a cycle
//   iter_cnt          (GCD_ITER_COUNT_EN only) saturating count of A/B writes
//
// Optional feature macro: GCD_ITER_COUNT_EN
module gcd_datapath #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             ld,
    input  logic             comp,
    input  logic             alu,
    input  logic             a_sel,
    input  logic             b_sel,
    input  logic             ans_en,
    output logic             a_eq_b,
    output logic             a_lt_b,
    output logic             a_gt_b,
    output logic [WIDTH-1:0] gcd_out,
    output logic             gcd_valid,
    output logic             proto_err
`ifdef GCD_ITER_COUNT_EN
    ,
    output logic [WIDTH-1:0] iter_cnt
`endif
);

    logic [WIDTH-1:0] a_q, b_q, d_q;
    logic [5:0]       stb;
    logic             multi_stb;
    logic             any_zero;

    assign stb       = {ld, comp, alu, a_sel, b_sel, ans_en};
    // Clearing the lowest set bit leaves something only when two or more bits are set.
    assign multi_stb = (stb & (stb - 6'd1)) != 6'd0;
    assign any_zero  = (a_q == '0) || (b_q == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q       <= '0;
            b_q       <= '0;
            d_q       <= '0;
            gcd_out   <= '0;
            a_eq_b    <= 1'b0;
            a_lt_b    <= 1'b0;
            a_gt_b    <= 1'b0;
            gcd_valid <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            gcd_valid <= 1'b0;
            if (multi_stb)
                proto_err <= 1'b1;

            // Only the highest-priority strobe acts.
            if (ld) begin
                a_q    <= a_in;
                b_q    <= b_in;
                a_eq_b <= 1'b0;
                a_lt_b <= 1'b0;
                a_gt_b <= 1'b0;
            end else if (a_sel) begin
                a_q <= d_q;
            end else if (b_sel) begin
                b_q <= d_q;
            end else if (alu) begin
                // The subtraction direction follows the registered flags, so
                // the smaller operand is always taken from the larger one.
                if (a_eq_b)
                    d_q <= '0;
                else if (a_gt_b)
                    d_q <= a_q - b_q;
                else
                    d_q <= b_q - a_q;
            end else if (comp) begin
                // A zero operand reports "equal" so the controller terminates.
                a_eq_b <= any_zero || (a_q == b_q);
                a_lt_b <= !any_zero && (a_q < b_q);
                a_gt_b <= !any_zero && (a_q > b_q);
            end else if (ans_en) begin
                gcd_out   <= any_zero ? (a_q | b_q) : a_q;
                gcd_valid <= 1'b1;
            end
        end
    end

`ifdef GCD_ITER_COUNT_EN
    // Counts accepted operand writes (a_sel or b_sel without ld). The count
    // saturates at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            iter_cnt <= '0;
        else if (ld)
            iter_cnt <= '0;
        else if ((a_sel || b_sel) && (iter_cnt != '1))
            iter_cnt <= iter_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_gcd_datapath.sv
module tb_gcd_datapath;
    localparam int WIDTH = 8;
    localparam logic [5:0] S_LD = 6'b100000, S_COMP = 6'b010000, S_ALU = 6'b001000,
                           S_ASEL = 6'b000100, S_BSEL = 6'b000010, S_ANS = 6'b000001;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [WIDTH-1:0] a_in = '0, b_in = '0;
    logic ld = 0, comp = 0, alu = 0, a_sel = 0, b_sel = 0, ans_en = 0;
    logic a_eq_b, a_lt_b, a_gt_b, gcd_valid, proto_err;
    logic [WIDTH-1:0] gcd_out;
`ifdef GCD_ITER_COUNT_EN
    logic [WIDTH-1:0] iter_cnt;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    gcd_datapath #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in),
        .ld(ld), .comp(comp), .alu(alu), .a_sel(a_sel), .b_sel(b_sel), .ans_en(ans_en),
        .a_eq_b(a_eq_b), .a_lt_b(a_lt_b), .a_gt_b(a_gt_b),
        .gcd_out(gcd_out), .gcd_valid(gcd_valid), .proto_err(proto_err)
`ifdef GCD_ITER_COUNT_EN
        , .iter_cnt(iter_cnt)
`endif
    );

    // Reference: GCD by the remainder form of Euclid's algorithm.
    function automatic int ref_gcd(input int a, input int b);
        int t;
        if (a == 0) return b;
        if (b == 0) return a;
        while (b != 0) begin t = a % b; a = b; b = t; end
        return a;
    endfunction

    // Reference: the number of subtract steps equals the sum of the Euclid quotients minus one.
    function automatic int ref_steps(input int a, input int b);
        int s, t;
        if (a == 0 || b == 0) return 0;
        s = 0;
        while (b != 0) begin s += a / b; t = a % b; a = b; b = t; end
        return s - 1;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // This task is entered at a negedge. It drives the strobes for one
    // cycle and returns at the next negedge.
    task automatic pulse(input logic [5:0] s);
        {ld, comp, alu, a_sel, b_sel, ans_en} = s;
        @(negedge clk);
        {ld, comp, alu, a_sel, b_sel, ans_en} = '0;
    endtask

    task automatic check_flags(input string tag, input int ma, input int mb);
        logic e, l, g;
        e = (ma == 0) || (mb == 0) || (ma == mb);
        l = !e && (ma < mb);
        g = !e && (ma > mb);
        chk({tag, "_eq"}, int'(a_eq_b), int'(e));
        chk({tag, "_lt"}, int'(a_lt_b), int'(l));
        chk({tag, "_gt"}, int'(a_gt_b), int'(g));
    endtask

    // Load a and b, then act as the controller until the flags report equal.
    task automatic run_gcd(input string tag, input int a, input int b);
        int ma, mb;
        bit done;
        a_in = WIDTH'(a); b_in = WIDTH'(b);
        pulse(S_LD);
        chk({tag, "_ldflags"}, int'({a_eq_b, a_lt_b, a_gt_b}), 0);
        ma = a; mb = b; done = 0;
        for (int i = 0; i < 600 && !done; i++) begin
            pulse(S_COMP);
            check_flags(tag, ma, mb);
            if (a_eq_b) done = 1;
            else begin
                pulse(S_ALU);
                if (a_gt_b) begin pulse(S_ASEL); ma -= mb; end
                else begin pulse(S_BSEL); mb -= ma; end
            end
        end
        chk({tag, "_terminated"}, int'(done), 1);
        pulse(S_ANS);
        chk({tag, "_gcd"}, int'(gcd_out), ref_gcd(a, b));
        chk({tag, "_valid_hi"}, int'(gcd_valid), 1);
`ifdef GCD_ITER_COUNT_EN
        chk({tag, "_iter"}, int'(iter_cnt), ref_steps(a, b));
`endif
        @(negedge clk);
        chk({tag, "_valid_lo"}, int'(gcd_valid), 0);
        chk({tag, "_gcd_hold"}, int'(gcd_out), ref_gcd(a, b));
    endtask

    initial begin
        int ra, rb;
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_flags", int'({a_eq_b, a_lt_b, a_gt_b}), 0);
        chk("rst_gcd", int'(gcd_out), 0);
        chk("rst_valid", int'(gcd_valid), 0);
        chk("rst_perr", int'(proto_err), 0);
        rst = 1'b1;
        @(negedge clk);

        // Strobes issued with no preceding load act on the zero reset values.
        pulse(S_COMP);
        check_flags("noload", 0, 0);
        pulse(S_ANS);
        chk("noload_gcd", int'(gcd_out), 0);
        chk("noload_valid", int'(gcd_valid), 1);

        run_gcd("g48_18", 48, 18);
        run_gcd("g17_17", 17, 17);
        run_gcd("g0_25", 0, 25);
        run_gcd("g0_0", 0, 0);
        run_gcd("g255_1", 255, 1);

        // Force extra writes after convergence. With A=B=1 the alu step
        // gives D=0, so A becomes 0 and gcd_out becomes A|B = 1.
        pulse(S_ALU);
        pulse(S_ASEL);
`ifdef GCD_ITER_COUNT_EN
        chk("sat_255", int'(iter_cnt), 255);
`endif
        pulse(S_ASEL);
`ifdef GCD_ITER_COUNT_EN
        chk("sat_hold", int'(iter_cnt), 255);
`endif
        pulse(S_COMP);
        check_flags("sat", 0, 1);
        pulse(S_ANS);
        chk("sat_gcd", int'(gcd_out), 1);

        // Randomized operand pairs
        for (int k = 0; k < 12; k++) begin
            ra = int'($urandom_range(0, 255));
            rb = int'($urandom_range(1, 255));
            if (k % 4 == 0) ra = rb * int'($urandom_range(1, 3)) % 256;
            run_gcd($sformatf("rnd%0d", k), ra, rb);
        end
        chk("perr_clean", int'(proto_err), 0);

        // Reset in the middle of an iteration: 60,48 gives D=12.
        a_in = 8'd60; b_in = 8'd48;
        pulse(S_LD);
        pulse(S_COMP);
        pulse(S_ALU);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_outs", int'({a_eq_b, a_lt_b, a_gt_b, gcd_valid, proto_err}), 0);
        chk("mid_rst_gcd", int'(gcd_out), 0);
`ifdef GCD_ITER_COUNT_EN
        chk("mid_rst_iter", int'(iter_cnt), 0);
`endif
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_novalid", int'(gcd_valid), 0);
        end
        pulse(S_ANS);
        chk("post_rst_d_cleared", int'(gcd_out), 0);
        run_gcd("g9_6", 9, 6);

        // Assert a_sel and b_sel together: a_sel wins and proto_err sets.
        a_in = 8'd40; b_in = 8'd10;
        pulse(S_LD);
        pulse(S_COMP);
        pulse(S_ALU);
        chk("perr_before", int'(proto_err), 0);
        pulse(S_ASEL | S_BSEL);
        chk("perr_set", int'(proto_err), 1);
        pulse(S_COMP);
        check_flags("dual_sel", 30, 10);
        pulse(S_ANS);
        chk("dual_sel_a", int'(gcd_out), 30);
        a_in = 8'd5; b_in = 8'd5;
        pulse(S_LD);
        chk("perr_sticky", int'(proto_err), 1);
        rst = 1'b0;
        @(negedge clk);
        chk("perr_rst", int'(proto_err), 0);
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/gcd_datapath.md
Name: gcd_datapath

Overview:
- Datapath partner of the GCD control FSM.
- Consumes the controller's one-hot-per-cycle strobes `ld`, `comp`, `alu`, `a_sel`, `b_sel` and `ans_en`.
- Returns registered compare flags `a_eq_b`, `a_lt_b` and `a_gt_b`.
- Holds the operand registers A and B, performs subtract-based Euclid steps and presents the final GCD with a valid pulse to the top level and the Nexys4 display logic.

Parameters:
- WIDTH, 8, operand and result width in bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- a_in  input  WIDTH  operand A, sampled on `ld`.
- b_in  input  WIDTH  operand B, sampled on `ld`.
- ld  input  1  load strobe.
- comp  input  1  compare strobe.
- alu  input  1  subtract strobe.
- a_sel  input  1  write the difference into A.
- b_sel  input  1  write the difference into B.
- ans_en  input  1  capture the result.
- a_eq_b  output  1  registered flag, A equal to B (or an operand is zero).
- a_lt_b  output  1  registered flag, A less than B.
- a_gt_b  output  1  registered flag, A greater than B.
- gcd_out  output  WIDTH  result register.
- gcd_valid  output  1  one-cycle pulse when gcd_out updates.
- proto_err  output  1  sticky flag for an illegal strobe combination.

Behaviour:
- Reset (rst low, asynchronous):
  - A, B, D (difference register), gcd_out and all three flags clear to 0.
  - gcd_valid and proto_err clear to 0.
  - Reset mid-iteration abandons the computation; no gcd_valid is produced.
- Strobes are sampled at the rising edge. Priority: ld > a_sel/b_sel > alu > comp > ans_en.
  - Only the highest-priority asserted strobe acts.
  - Any cycle with more than one strobe high sets proto_err; it stays set until reset.
- ld:
  - A <= a_in, B <= b_in; flags clear to 0.
  - A second ld mid-iteration restarts cleanly.
- comp: flags register from the current A and B.
  - If A==0 or B==0: a_eq_b=1, a_lt_b=0, a_gt_b=0. Zero operands therefore terminate instead of looping forever.
  - Otherwise exactly one of the three flags is 1, from an unsigned compare.
  - Flags are valid from the cycle after comp and hold until the next comp or ld.
- alu: D <= A-B when registered a_gt_b is set, else D <= B-A.
  - Unsigned, WIDTH bits. Underflow cannot occur given the flag ordering.
  - If a_eq_b is set, D <= 0.
- a_sel: A <= D.
- b_sel: B <= D. If a_sel and b_sel are both high, a_sel wins (and proto_err sets).
- ans_en: gcd_out <= (A|B) when either register is zero, else A.
  - The zero-operand case yields the nonzero operand; 0,0 yields 0.
  - gcd_valid is high for exactly the following cycle.
  - gcd_out holds until the next ans_en or reset.
- Latency per Euclid step: comp, alu, then a_sel/b_sel, so 3 strobe cycles plus controller pipelining. Datapath latency from any strobe to its register update is 1 edge.
- A strobe arriving with no preceding load acts on the reset values (A=B=0) and yields gcd_out=0.

Optional Feature:
- Macro: GCD_ITER_COUNT_EN.
- Defined:
  - Adds output `iter_cnt` [WIDTH-1:0].
  - Cleared on reset and on ld; increments on each accepted a_sel/b_sel write.
  - Saturates at all-ones; never wraps.
  - Frozen value is readable after gcd_valid.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- ld 48,18 then drive the controller sequence -> flags gt, then lt/gt alternate per Euclid; gcd_out=6, gcd_valid one cycle; iter_cnt=4.
- ld 17,17, comp, ans_en -> a_eq_b=1 after the first comp, gcd_out=17, no subtractions, iter_cnt=0.
- ld 0,25, comp -> a_eq_b=1; ans_en -> gcd_out=25. ld 0,0 -> gcd_out=0.
- ld 255,1, full loop -> 254 b... A-writes, gcd_out=1; iter_cnt=254, and saturates at 255 if extended with forced extra a_sel strobes.
- Pull rst low while D=12 mid-iteration -> all outputs 0 within the same cycle; no gcd_valid after release; a new ld 9,6 yields 3.
- Assert a_sel and b_sel together -> A updated, B unchanged, proto_err=1 sticky until reset.
